// File: rtl/bbox_scanner.sv
// bbox_scanner: walks every pixel of an inclusive integer box, one coordinate per valid/ready beat.
// Define BBOX_SCAN_SERPENTINE_EN for boustrophedon (alternating direction) row order.
module bbox_scanner #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             box_valid,
  output logic             box_ready,
  input  logic [WIDTH-1:0] XMIN,
  input  logic [WIDTH-1:0] XMAX,
  input  logic [WIDTH-1:0] YMIN,
  input  logic [WIDTH-1:0] YMAX,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [WIDTH-1:0] pix_x,
  output logic [WIDTH-1:0] pix_y,
  output logic             pix_eol,
  output logic             pix_last,
  output logic             box_empty,
  output logic             busy
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state, state_d;
  logic [WIDTH-1:0] xmin, xmax, ymax, x, y, row_end, x_step, x_row;
  logic accept, degen, beat;
`ifdef BBOX_SCAN_SERPENTINE_EN
  logic odd;
  assign row_end = odd ? xmin : xmax;
  assign x_step  = odd ? x - 1'b1 : x + 1'b1;
  assign x_row   = x;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) odd <= 1'b0;
    else if (accept) odd <= 1'b0;
    else if (beat & pix_eol & !pix_last) odd <= ~odd;
`else
  assign row_end = xmax;
  assign x_step  = x + 1'b1;
  assign x_row   = xmin;
`endif
  always_comb begin
    box_ready = state == IDLE;
    busy      = state == SCAN;
    pix_valid = busy;
    accept    = box_ready & box_valid;
    degen     = (XMIN > XMAX) | (YMIN > YMAX);
    beat      = pix_valid & pix_ready;
    pix_eol   = busy & (x == row_end);
    pix_last  = pix_eol & (y == ymax);
    state_d   = (accept & !degen) ? SCAN : (beat & pix_last) ? IDLE : state;
  end
  // Equality-only end tests keep boxes touching 2^WIDTH-1 from wrapping.
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state     <= IDLE;
      xmin      <= '0;
      xmax      <= '0;
      ymax      <= '0;
      x         <= '0;
      y         <= '0;
      box_empty <= 1'b0;
    end else begin
      state     <= state_d;
      box_empty <= accept & degen;
      if (accept) begin
        xmin <= XMIN;
        xmax <= XMAX;
        ymax <= YMAX;
        x    <= XMIN;
        y    <= YMIN;
      end else if (beat & !pix_last) begin
        x <= pix_eol ? x_row : x_step;
        y <= pix_eol ? y + 1'b1 : y;
      end
    end
  assign pix_x = x;
  assign pix_y = y;
endmodule

// File: tb/tb_bbox_scanner.sv
// tb_bbox_scanner: directed boxes checked against a queue-based pixel model plus literal sequences.
module tb_bbox_scanner;
  typedef struct packed {logic [15:0] x; logic [15:0] y; logic eol; logic last;} pix_t;
`ifdef BBOX_SCAN_SERPENTINE_EN
  localparam bit SERP = 1'b1;
`else
  localparam bit SERP = 1'b0;
`endif
  logic CLK = 0, RST_N = 1, box_valid = 0, pix_ready = 1, tog = 0;
  logic [15:0] XMIN = 0, XMAX = 0, YMIN = 0, YMAX = 0;
  logic box_ready, pix_valid, pix_eol, pix_last, box_empty, busy;
  logic [15:0] pix_x, pix_y;
  int n_chk = 0, n_pass = 0, n_empty = 0;
  bit exp_empty = 0;
  pix_t q[$], got[$], e[$];

  bbox_scanner #(.WIDTH(16)) dut (
    .CLK(CLK), .RST_N(RST_N), .box_valid(box_valid), .box_ready(box_ready),
    .XMIN(XMIN), .XMAX(XMAX), .YMIN(YMIN), .YMAX(YMAX),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
    .pix_eol(pix_eol), .pix_last(pix_last), .box_empty(box_empty), .busy(busy)
  );

  always #5 CLK = ~CLK;

  function automatic pix_t mk(int x, int y, bit eol, bit last);
    mk = {x[15:0], y[15:0], eol, last};
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, act, req, $time);
  endtask

  // Model: on each accepted box, enumerate its pixels in traversal order.
  always @(negedge CLK) begin
    if (!RST_N) begin
      chk("reset_outputs", {box_ready, pix_valid, pix_x, pix_y, pix_eol, pix_last, box_empty, busy},
          {1'b1, 37'd0});
      q.delete();
      exp_empty = 0;
    end else begin
      chk("box_empty", box_empty, exp_empty);
      if (box_empty) n_empty++;
      exp_empty = 0;
      chk("pix_valid", pix_valid, q.size() != 0);
      chk("box_ready", box_ready, q.size() == 0);
      chk("busy", busy, q.size() != 0);
      if (pix_valid && q.size() != 0) begin
        chk("pixel", {pix_x, pix_y, pix_eol, pix_last}, q[0]);
        if (pix_ready) begin
          got.push_back({pix_x, pix_y, pix_eol, pix_last});
          void'(q.pop_front());
        end
      end
      if (box_valid && box_ready) begin
        if (XMIN > XMAX || YMIN > YMAX) exp_empty = 1;
        else
          for (int r = 0; r <= int'(YMAX) - int'(YMIN); r++)
            for (int k = 0; k <= int'(XMAX) - int'(XMIN); k++)
              q.push_back(mk((SERP && r % 2 == 1) ? int'(XMAX) - k : int'(XMIN) + k, int'(YMIN) + r,
                             k == int'(XMAX) - int'(XMIN),
                             k == int'(XMAX) - int'(XMIN) && r == int'(YMAX) - int'(YMIN)));
      end
    end
  end

  initial forever begin
    @(posedge CLK);
    #1;
    if (tog) pix_ready = ~pix_ready;
  end

  task automatic send_box(input int x0, input int x1, input int y0, input int y1);
    @(posedge CLK);
    #1;
    box_valid = 1;
    XMIN = x0[15:0]; XMAX = x1[15:0]; YMIN = y0[15:0]; YMAX = y1[15:0];
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (box_ready) break;
      if (i == 49) chk("accept_timeout", 1, 0);
    end
    @(posedge CLK);
    #1;
    box_valid = 0;
    XMIN = 16'($urandom); XMAX = 16'($urandom); YMIN = 16'($urandom); YMAX = 16'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge CLK);
      #1;
      if (q.size() == 0 && !pix_valid) return;
    end
    chk("done_timeout", 1, 0);
  endtask

  task automatic check_got(input string n);
    chk({n, "_count"}, got.size(), e.size());
    for (int i = 0; i < e.size() && i < got.size(); i++) chk(n, got[i], e[i]);
    got.delete();
  endtask

  initial begin
    #1 RST_N = 0;
    repeat (3) @(negedge CLK);
    #2 RST_N = 1;
    send_box(2, 4, 1, 2);
    wait_done();
`ifdef BBOX_SCAN_SERPENTINE_EN
    e = '{mk(2,1,0,0), mk(3,1,0,0), mk(4,1,1,0), mk(4,2,0,0), mk(3,2,0,0), mk(2,2,1,1)};
`else
    e = '{mk(2,1,0,0), mk(3,1,0,0), mk(4,1,1,0), mk(2,2,0,0), mk(3,2,0,0), mk(4,2,1,1)};
`endif
    check_got("box_2_4_1_2");
    send_box(5, 5, 7, 7);
    wait_done();
    e = '{mk(5,7,1,1)};
    check_got("single_pixel");
    send_box(9, 3, 0, 0);
    send_box(0, 0, 5, 4);
    repeat (3) @(negedge CLK);
    chk("empty_pulses", n_empty, 2);
    chk("empty_no_pixels", got.size(), 0);
    tog = 1;
    send_box(0, 2, 0, 1);
    wait_done();
    @(posedge CLK);
    #2 tog = 0; pix_ready = 1;
`ifdef BBOX_SCAN_SERPENTINE_EN
    e = '{mk(0,0,0,0), mk(1,0,0,0), mk(2,0,1,0), mk(2,1,0,0), mk(1,1,0,0), mk(0,1,1,1)};
`else
    e = '{mk(0,0,0,0), mk(1,0,0,0), mk(2,0,1,0), mk(0,1,0,0), mk(1,1,0,0), mk(2,1,1,1)};
`endif
    check_got("stall_toggle");
    send_box(16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    wait_done();
    repeat (4) @(negedge CLK);
    e = '{mk(16'hFFFE,16'hFFFF,0,0), mk(16'hFFFF,16'hFFFF,1,1)};
    check_got("max_corner");
    send_box(0, 2, 0, 2);
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      #1;
      if (got.size() >= 3) break;
      if (i == 49) chk("pixel3_timeout", 1, 0);
    end
    #1 RST_N = 0;
    #1 chk("async_reset", {box_ready, pix_valid, pix_x, pix_y, pix_eol, pix_last, box_empty, busy},
           {1'b1, 37'd0});
    repeat (2) @(negedge CLK);
    #2 RST_N = 1;
    got.delete();
    send_box(1, 1, 1, 1);
    wait_done();
    repeat (3) @(negedge CLK);
    e = '{mk(1,1,1,1)};
    check_got("after_reset");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
